// File: rtl/jstk2_pkg.sv
// Shared JSTK2 frame definitions: sizes, byte positions, responder states and
// the payload packer used by both the responder and its bench.
package jstk2_pkg;

  localparam int unsigned JSTK2_FRAME_BYTES = 5;
  localparam int unsigned JSTK2_POS_W       = 10;
  localparam int unsigned JSTK2_FRAME_W     = JSTK2_FRAME_BYTES * 8;

  // Byte order on the wire; byte 0 is shifted out first.
  localparam int unsigned X_LO = 0;
  localparam int unsigned X_HI = 1;
  localparam int unsigned Y_LO = 2;
  localparam int unsigned Y_HI = 3;
  localparam int unsigned BTN  = 4;

  typedef enum logic [1:0] {
    WAIT_HIGH,
    IDLE,
    ACTIVE
  } responder_state_t;

  // btns = {trigger, joystick}
  function automatic logic [JSTK2_FRAME_W-1:0] pack_frame(
    input logic [JSTK2_POS_W-1:0] x,
    input logic [JSTK2_POS_W-1:0] y,
    input logic [1:0]             btns
  );
    logic [7:0]               b [JSTK2_FRAME_BYTES];
    logic [JSTK2_FRAME_W-1:0] f;
    b[X_LO] = x[7:0];
    b[X_HI] = {6'b0, x[9:8]};
    b[Y_LO] = y[7:0];
    b[Y_HI] = {6'b0, y[9:8]};
    b[BTN]  = {6'b0, btns};
    f = '0;
    for (int unsigned i = 0; i < JSTK2_FRAME_BYTES; i++) begin
      f[JSTK2_FRAME_W-1-8*i -: 8] = b[i];
    end
    return f;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchroniser for an asynchronous SPI pin, followed by one
// edge-detect register producing single-cycle rise/fall strobes.
module spi_pin_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/jstk2_spi_responder.sv
// SPI mode-0 responder emulating a Pmod JSTK2: streams a snapshot of the
// X/Y/button inputs MSB first on MISO for every SS-low transaction.
module jstk2_spi_responder
  import jstk2_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = JSTK2_FRAME_BYTES,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [JSTK2_POS_W-1:0] x_pos,
  input  logic [JSTK2_POS_W-1:0] y_pos,
  input  logic                   btn_jstk,
  input  logic                   btn_trig,
  input  logic                   SS,
  input  logic                   SCLK,
  output logic                   MISO,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_err
);

  localparam int unsigned FW      = FRAME_BYTES * 8;
  localparam int unsigned CNT_SAT = FW + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_SAT + 1);
  localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);

  logic ss_rise, ss_fall, sclk_rise, sclk_fall;

  spi_pin_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (SS),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_pin_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (SCLK),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  responder_state_t  state_q, state_d;
  logic [FW-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic              ss_low_q;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [JSTK2_FRAME_W-1:0] payload;
  logic [FW-1:0]            frame_load;

  assign payload = pack_frame(x_pos, y_pos, {btn_trig, btn_jstk});

  always_comb begin
    frame_load = '0;
    frame_load[FW-1 -: JSTK2_FRAME_W] = payload;
  end

  // The SS synchroniser resets to "high", so its level is only trusted once the
  // chain has been refilled from the pin; a low pin then shows up as a fall,
  // which ss_low_q remembers until SS is genuinely seen high.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      WAIT_HIGH: begin
        if (flush_q < FLUSH_W'(SYNC_STAGES)) begin
          flush_d = flush_q + FLUSH_W'(1);
        end else if (!ss_low_q && !ss_fall) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (ss_fall) begin
          state_d = ACTIVE;
          sr_d    = frame_load;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_W'(FW)) done_d = 1'b1;
          else                     err_d  = 1'b1;
        end else begin
          if (sclk_rise && cnt_q != CNT_W'(CNT_SAT)) cnt_d = cnt_q + CNT_W'(1);
          if (sclk_fall) sr_d = {sr_q[FW-2:0], 1'b0};
        end
      end
      default: state_d = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_HIGH;
      sr_q     <= '0;
      cnt_q    <= '0;
      flush_q  <= '0;
      ss_low_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (ss_fall)      ss_low_q <= 1'b1;
      else if (ss_rise) ss_low_q <= 1'b0;
    end
  end

  assign busy       = (state_q == ACTIVE);
  assign MISO       = busy & sr_q[FW-1];
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Bench for jstk2_spi_responder: acts as SPI initiator, predicts each frame
// from the JSTK2 byte layout and scores frames when the DUT pulses done/err.
module tb_jstk2_spi_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic       btn_jstk = 1'b0;
  logic       btn_trig = 1'b0;
  logic       SS = 1'b1;
  logic       SCLK = 1'b0;
  logic       MISO, busy, frame_done, frame_err;

  always #5 clk = ~clk;

  jstk2_spi_responder #(
    .FRAME_BYTES (5),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .btn_jstk   (btn_jstk),
    .btn_trig   (btn_trig),
    .SS         (SS),
    .SCLK       (SCLK),
    .MISO       (MISO),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic [63:0] bits;
    int          nbits;
    bit          done;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] cap = '0;
  int          ncap = 0;
  int          frame_no = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Wire stream of a JSTK2 frame: bytes X lo, X hi, Y lo, Y hi, buttons, then zeros.
  function automatic logic [63:0] model_stream(input int x, input int y,
                                               input int bj, input int bt, input int n);
    int          b[8];
    logic [63:0] s;
    b = '{default: 0};
    s = '0;
    b[0] = x % 256;
    b[1] = x / 256;
    b[2] = y % 256;
    b[3] = y / 256;
    b[4] = bt * 2 + bj;
    for (int k = 0; k < n && k < 64; k++) s[63-k] = ((b[k/8] >> (7 - k % 8)) & 1) != 0;
    return s;
  endfunction

  // Initiator-side capture: MISO sampled on each SCLK rise while SS is low.
  initial forever begin
    @(posedge SCLK or negedge SS);
    if (!SS && !SCLK) begin
      cap  = '0;
      ncap = 0;
    end else if (!SS && SCLK && ncap < 64) begin
      cap[63-ncap] = MISO;
      ncap++;
    end
  end

  // Monitor: every done/err pulse retires one predicted frame.
  initial forever begin
    exp_t        e;
    logic [63:0] mask;
    @(negedge clk);
    if (!rst && (frame_done || frame_err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b, expected no pulse",
                 frame_done, frame_err);
      end else begin
        e = sb.pop_front();
        mask = (e.nbits >= 64) ? '1 : ~(64'hFFFF_FFFF_FFFF_FFFF >> e.nbits);
        check($sformatf("frame%0d_done", frame_no), 64'(frame_done), 64'(e.done));
        check($sformatf("frame%0d_err", frame_no), 64'(frame_err), 64'(!e.done));
        check($sformatf("frame%0d_data", frame_no), cap & mask, e.bits & mask);
        frame_no++;
      end
    end
  end

  task automatic sclk_cycles(input int n, input int chg_bit, input logic [9:0] newx);
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b1;
      if (i == chg_bit) x_pos = newx;
      repeat (10) @(negedge clk);
      SCLK = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic frame(input logic [9:0] x, input logic [9:0] y, input logic bj,
                       input logic bt, input int n, input int chg_bit,
                       input logic [9:0] newx, input int ss_high);
    exp_t e;
    x_pos = x; y_pos = y; btn_jstk = bj; btn_trig = bt;
    repeat (2) @(negedge clk);
    check("idle_miso", 64'(MISO), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    e.bits  = model_stream(int'(x), int'(y), int'(bj), int'(bt), n);
    e.nbits = n;
    e.done  = (n == 40);
    sb.push_back(e);
    SS = 1'b0;
    repeat (10) @(negedge clk);
    check("active_busy", 64'(busy), 64'(1));
    sclk_cycles(n, chg_bit, newx);
    SS = 1'b1;
    repeat (ss_high) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_miso", 64'(MISO), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(frame_done), 64'(0));
    check("rst_err", 64'(frame_err), 64'(0));
    rst = 1'b0;
    repeat (6) @(negedge clk);

    frame(10'h2A5, 10'h1FF, 1'b1, 1'b0, 40, -1, '0, 20);
    frame(10'h2A5, 10'h1FF, 1'b1, 1'b0, 40, 4, 10'h000, 20);
    frame(10'h000, 10'h1FF, 1'b1, 1'b0, 40, -1, '0, 20);
    frame(10'h155, 10'h0AA, 1'b0, 1'b1, 20, -1, '0, 20);
    frame(10'h3FF, 10'h000, 1'b1, 1'b1, 40, -1, '0, 20);
    frame(10'h123, 10'h321, 1'b0, 1'b1, 48, -1, '0, 20);
    frame(10'h000, 10'h3FF, 1'b0, 1'b0, 0, -1, '0, 20);

    // Reset in the middle of a transaction with SS held low throughout.
    x_pos = 10'h0F0; y_pos = 10'h30F;
    SS = 1'b0;
    repeat (10) @(negedge clk);
    sclk_cycles(12, -1, '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_miso", 64'(MISO), 64'(0));
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b1;
      repeat (5) @(negedge clk);
      check("ss_low_sclk_busy", 64'(busy), 64'(0));
      check("ss_low_sclk_miso", 64'(MISO), 64'(0));
      repeat (5) @(negedge clk);
      SCLK = 1'b0;
      repeat (10) @(negedge clk);
    end
    SS = 1'b1;
    repeat (8) @(negedge clk);
    frame(10'h0F0, 10'h30F, 1'b1, 1'b0, 40, -1, '0, 20);

    // Back-to-back frames with the minimum SS high time.
    frame(10'h1A2, 10'h2B3, 1'b0, 1'b1, 40, -1, '0, 4);
    frame(10'h2C4, 10'h0D5, 1'b1, 1'b0, 40, -1, '0, 20);

    for (int r = 0; r < 8; r++) begin
      logic [9:0] rx, ry;
      int         n;
      rx = 10'($urandom_range(0, 1023));
      ry = 10'($urandom_range(0, 1023));
      n  = (r % 3 == 2) ? int'($urandom_range(0, 47)) : 40;
      frame(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n, -1, '0,
            int'($urandom_range(4, 12)));
    end

    for (int t = 0; t < 200 && sb.size() > 0; t++) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse: got no pulse, expected %s", e.done ? "frame_done" : "frame_err");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
